instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Front end of the single-cycle-decode datapath. Fetches 32-bit instruction words from instruction memory over a request/acknowledge handshake, holds them in a small prefetch FIFO, and presents the head instruction's `opcode` and `func` fields, plus the full word and its PC, to the control unit and decode stage over a valid/ready handshake. Branch and jump redirects flush the FIFO and restart fetch at the new PC.

## Interface

**Parameters**
- `ADDR_W`, 32: PC and memory address width.
- `DEPTH`, 2: prefetch FIFO entries; power of 2, minimum 2.
- `RESET_PC`, 0: first fetch address; must be word-aligned.

**Ports**
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDR_W  fetch byte address; bits [1:0] are always 0.
- `imem_ack`  in  1  memory response; `imem_rdata` is valid in this cycle.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  single-cycle pulse: flush and refetch.
- `redirect_pc`  in  ADDR_W  new PC; bits [1:0] are ignored and forced to 0.
- `dec_valid`  out  1  head instruction available.
- `dec_ready`  in  1  decode stage accepts the head instruction.
- `opcode`  out  6  `instr[31:26]` of the head instruction.
- `func`  out  5  `instr[4:0]` of the head instruction.
- `instr`  out  32  full head instruction word.
- `instr_pc`  out  ADDR_W  PC of the head instruction.

## Operation

- **FSM states**
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DISCARD: request outstanding whose data must be dropped.
- **IDLE → WAIT** when `count < DEPTH`. `imem_req` rises and `imem_addr` is set to `fetch_pc`.
- **In WAIT**, `imem_req` and `imem_addr` are held stable until `imem_ack`. On ack:
  - `imem_rdata` and `imem_addr` are pushed into the FIFO.
  - `fetch_pc` advances by 4; it wraps modulo 2^ADDR_W.
  - The FSM returns to IDLE. At most one request is outstanding.
- **Pop** occurs when `dec_valid & dec_ready`. Push and pop in the same cycle leave `count` unchanged.
- **Head outputs:** when `count == 0`, `opcode`, `func`, `instr` and `instr_pc` are driven to 0.
- **Redirect** has priority over every other event in its cycle:
  - A pop completing in that cycle counts as completed.
  - The FIFO is then flushed (`count` becomes 0) and `fetch_pc` is loaded with `redirect_pc`.
  - In WAIT without `imem_ack`, the FSM moves to DISCARD. `imem_req` stays high with the old address until ack, and that data is dropped.
  - In WAIT with `imem_ack` in the same cycle, the acked data is dropped and the FSM goes to IDLE.
  - A redirect during DISCARD updates `fetch_pc` and leaves the FSM in DISCARD.
- **DISCARD → IDLE** on `imem_ack`; no push occurs.
- **Reset mid-operation:** everything is cleared immediately, including any outstanding request. The memory must tolerate an abandoned request.

## Timing

- **Reset values:**
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `dec_valid` = 0.
  - `opcode`, `func`, `instr` = 0, `instr_pc` = 0.
  - FSM = IDLE, `fetch_pc` = `RESET_PC`, `count` = 0.
- **First request:** `imem_req` goes high after the first rising edge at which `rst_n` is high.
- **Fetch latency:** `imem_ack` in cycle n gives `dec_valid` = 1 in cycle n+1.
- **Request spacing:** the next request is issued no earlier than cycle n+1 after an ack in cycle n. Back-to-back zero-wait memory therefore gives one instruction every 2 cycles.
- **After redirect:** a redirect in cycle r with the FSM in IDLE puts `imem_req` with `redirect_pc` in cycle r+1. `dec_valid` is 0 from cycle r+1.
- **Full FIFO:** `count == DEPTH` blocks new requests. A request already outstanding always has a free slot to land in.
- **Output timing:** all outputs are registered or derived from registered state only. Exception: the bypass path, see Configuration.

## Configuration

- **`FETCH_BYPASS_EN` defined:**
  - When `count == 0`, the FSM is in WAIT, `imem_ack` = 1 and `redirect` = 0, the acked word is presented combinationally in the same cycle (`dec_valid` = 1).
  - If `dec_ready` = 1 in that cycle, the word is consumed and not pushed.
  - If `dec_ready` = 0, the word is pushed normally.
  - Fetch latency becomes 0 cycles.
- **`FETCH_BYPASS_EN` not defined:** there is no combinational path from memory to the decode outputs, and latency is 1 cycle as above.

## Test plan

- **Reset then free-running fetch.**
  - Stimulus: `RESET_PC` = 0, memory acks 1 cycle after each request, `dec_ready` = 1.
  - Required: `imem_addr` sequence 0, 4, 8, 12. Each instruction appears 1 cycle after its ack with the correct `opcode`/`func` split. For example, 0x0400_0003 gives `opcode` = 000001 and `func` = 00011.
- **Back-pressure.**
  - Stimulus: `dec_ready` = 0.
  - Required: exactly `DEPTH` = 2 requests are issued, then `imem_req` stays 0. Raising `dec_ready` drains 0x0, 0x4 in order, and fetching resumes at 0x8.
- **Redirect while a request is outstanding.**
  - Stimulus: pulse `redirect` with `redirect_pc` = 0x100 during WAIT at address 0x8; ack 3 cycles later.
  - Required: the 0x8 data is never presented, and the next request is to 0x100.
- **Redirect coincident with ack and pop.**
  - Required: the popped instruction counts as consumed, the acked word is dropped, and `dec_valid` = 0 on the next cycle.
- **Asynchronous reset mid-fetch.**
  - Stimulus: drop `rst_n` between clock edges while `count` = 1.
  - Required: `imem_req`, `dec_valid`, `opcode` and `func` are 0 immediately, before the next edge.
- **Address wrap and misaligned redirect.**
  - Stimulus: `redirect_pc` = 0xFFFF_FFFE.
  - Required: `imem_addr` = 0xFFFF_FFFC, then 0x0000_0000.
  - With `FETCH_BYPASS_EN` defined: `dec_valid` rises in the ack cycle.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack channel, redirect
// input, and the valid/ready decode channel carrying the head instruction.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_valid;
  logic              dec_ready;
  logic [5:0]        opcode;
  logic [4:0]        func;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, dec_valid, opcode, func, instr, instr_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, dec_ready
  );

  // memory / decode side
  modport slave (
    input  imem_req, imem_addr, dec_valid, opcode, func, instr, instr_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request at a time, a DEPTH-entry
// prefetch FIFO, and opcode/func split of the head word for the control unit.
// Redirect flushes the FIFO; an in-flight request is drained in DISCARD.
// Optional macro FETCH_BYPASS_EN: forward an acked word straight to decode
// when the FIFO is empty (zero-cycle fetch latency).
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DISC = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic [31:0]       r_fifo_instr [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];
  logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              w_empty, w_ack_wait, w_bypass, w_valid, w_push, w_pop;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [31:0]       w_head_instr;
  logic [ADDR_W-1:0] w_head_pc;

  assign w_empty    = (r_count == '0);
  assign w_ack_wait = (r_state == S_WAIT) && bus.imem_ack;
  // low two bits of the redirect target are forced to zero (word aligned)
  assign w_redir_pc = bus.redirect_pc & ~ADDR_W'(3);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty && w_ack_wait && !bus.redirect;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_valid = !w_empty || w_bypass;
  // a bypassed word never occupies a slot, so only real entries are popped
  assign w_pop   = !w_empty && bus.dec_ready;
  assign w_push  = w_ack_wait && !bus.redirect && !(w_bypass && bus.dec_ready);

  // head selection; zero when nothing is available
  always_comb begin
    w_head_instr = '0;
    w_head_pc    = '0;
    if (w_bypass) begin
      w_head_instr = bus.imem_rdata;
      w_head_pc    = r_req_addr;
    end else if (!w_empty) begin
      w_head_instr = r_fifo_instr[r_rd_ptr];
      w_head_pc    = r_fifo_pc[r_rd_ptr];
    end
  end

  assign bus.imem_req  = (r_state != S_IDLE);
  assign bus.imem_addr = r_req_addr;
  assign bus.dec_valid = w_valid;
  assign bus.instr     = w_head_instr;
  assign bus.instr_pc  = w_head_pc;
  assign bus.opcode    = w_head_instr[31:26];
  assign bus.func      = w_head_instr[4:0];

  // request FSM and fetch PC; redirect wins over every other event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_req_addr <= w_redir_pc;
            r_state    <= S_WAIT;
          end else if (r_count < FULL) begin
            r_req_addr <= r_fetch_pc;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_state    <= bus.imem_ack ? S_IDLE : S_DISC;
          end else if (bus.imem_ack) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            r_state    <= S_IDLE;
          end
        end
        S_DISC: begin
          if (bus.redirect) r_fetch_pc <= w_redir_pc;
          if (bus.imem_ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO occupancy and pointers; redirect flushes after any same-cycle pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through count, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
      r_fifo_pc[r_wr_ptr]    <= r_req_addr;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scripted scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32)) bus();

  instr_fetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus control
  bit g_ready;
  int lat = 1;
  bit lat_rand;
  int cur_lat;
  int mw;

  // reference model: outstanding request, discard flag, fetch PC, queue of PCs
  bit          m_out, m_disc;
  logic [31:0] m_addr, m_fpc;
  logic [31:0] m_q[$];
  logic [108:0] exp_vec;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0400_0003;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [108:0] obs();
    return {bus.imem_req, bus.imem_req ? bus.imem_addr : 32'h0, bus.dec_valid,
            bus.instr, bus.instr_pc, bus.opcode, bus.func};
  endfunction

  function automatic bit model_byp();
`ifdef FETCH_BYPASS_EN
    return (m_q.size() == 0) && m_out && !m_disc && bus.imem_ack && !bus.redirect;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_out = 0; m_disc = 0; m_addr = 32'h0; m_fpc = 32'h0;
    m_q.delete();
  endtask

  task automatic model_update();
    int sz;
    bit byp, rd;
    sz  = m_q.size();
    byp = model_byp();
    rd  = (sz != 0 || byp) && bus.dec_ready;
    if (bus.redirect) begin
      m_q.delete();
      m_fpc = bus.redirect_pc & 32'hFFFF_FFFC;
      if (m_out) begin
        if (bus.imem_ack) begin m_out = 0; m_disc = 0; end
        else m_disc = 1;
      end else begin
        m_out = 1; m_addr = m_fpc;
      end
    end else begin
      if (rd && sz != 0) void'(m_q.pop_front());
      if (m_out) begin
        if (bus.imem_ack) begin
          if (!m_disc) begin
            if (!(byp && bus.dec_ready)) m_q.push_back(m_addr);
            m_fpc = m_fpc + 32'd4;
          end
          m_out = 0; m_disc = 0;
        end
      end else if (sz < DEPTH) begin
        m_out = 1; m_addr = m_fpc;
      end
    end
  endtask

  // advance one cycle: model follows the edge, then new inputs at negedge
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_update();
    @(negedge clk);
    if (rst_n && bus.imem_req) begin
      if (mw == 0) cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat;
      if (mw >= cur_lat) begin
        bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(bus.imem_addr); mw = 0;
      end else begin
        bus.imem_ack = 1'b0; bus.imem_rdata = $urandom; mw++;
      end
    end else begin
      bus.imem_ack = 1'b0; bus.imem_rdata = $urandom; mw = 0;
    end
    bus.redirect    = 1'b0;
    bus.redirect_pc = $urandom;
    bus.dec_ready   = g_ready;
  endtask

  // expected outputs for the current cycle
  task automatic eval();
    bit byp, v;
    logic [31:0] hp, hi;
    #1;
    byp = model_byp();
    v   = (m_q.size() != 0) || byp;
    hp  = byp ? m_addr : ((m_q.size() != 0) ? m_q[0] : 32'h0);
    hi  = v ? mem_word(hp) : 32'h0;
    exp_vec = {m_out, m_out ? m_addr : 32'h0, v, hi, hp, hi[31:26], hi[4:0]};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.redirect = 1'b0; bus.dec_ready = g_ready;
    mw = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    g_ready = 1'b1; lat = 1; lat_rand = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    n_cmp++;
    if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    n_cmp++;
    if (bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.dec_valid); end
    n_cmp++;
    if ({bus.opcode, bus.func} !== 11'h0) begin n_bad++; $display("FAIL reset_opfunc: got %h want 0", {bus.opcode, bus.func}); end
    n_cmp++;
    if ({bus.instr, bus.instr_pc} !== 64'h0) begin n_bad++; $display("FAIL reset_head: got %h want 0", {bus.instr, bus.instr_pc}); end
    n_cmp++;
    rst_n = 1'b1;
    tick(); eval();
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL first_req: got %b/%h want 1/0", bus.imem_req, bus.imem_addr);
    end
    n_cmp++;
  endtask

  task automatic test_free_run();
    logic [31:0] acks[$];
    bit op_seen = 0;
    for (int c = 0; c < 40 && acks.size() < 4; c++) begin
      if (c > 0) begin tick(); eval(); end
      if (obs() !== exp_vec) begin n_bad++; $display("FAIL free_run c%0d: got %h want %h", c, obs(), exp_vec); end
      n_cmp++;
      if (bus.imem_ack) acks.push_back(bus.imem_addr);
      if (bus.dec_valid && bus.instr_pc == 32'h0 && !op_seen) begin
        op_seen = 1;
        if ({bus.opcode, bus.func} !== {6'b000001, 5'b00011}) begin
          n_bad++; $display("FAIL free_run_split: got %b_%b want 000001_00011", bus.opcode, bus.func);
        end
        n_cmp++;
      end
    end
    if (acks.size() != 4 || acks[0] !== 32'h0 || acks[1] !== 32'h4 || acks[2] !== 32'h8 || acks[3] !== 32'hC) begin
      n_bad++; $display("FAIL free_run_addrs: got %p want 0,4,8,c", acks);
    end
    n_cmp++;
    if (!op_seen) begin n_bad++; $display("FAIL free_run_pc0: got never-presented want presented"); end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    int nack = 0;
    logic [31:0] pops[$];
    logic [31:0] nxt = 32'hDEAD_BEEF;
    bit got = 0;
    g_ready = 0; lat = 1; lat_rand = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      tick(); eval();
      if (obs() !== exp_vec) begin n_bad++; $display("FAIL bp_hold c%0d: got %h want %h", c, obs(), exp_vec); end
      n_cmp++;
      if (bus.imem_ack) nack++;
    end
    if (nack != DEPTH || bus.imem_req !== 1'b0) begin
      n_bad++; $display("FAIL bp_reqs: got %0d acks req=%b want %0d acks req=0", nack, bus.imem_req, DEPTH);
    end
    n_cmp++;
    g_ready = 1;
    for (int c = 0; c < 20 && !(pops.size() >= 2 && got); c++) begin
      tick(); eval();
      if (obs() !== exp_vec) begin n_bad++; $display("FAIL bp_drain c%0d: got %h want %h", c, obs(), exp_vec); end
      n_cmp++;
      if (bus.dec_valid && bus.dec_ready) pops.push_back(bus.instr_pc);
      if (bus.imem_req && !got) begin got = 1; nxt = bus.imem_addr; end
    end
    if (pops.size() < 2 || pops[0] !== 32'h0 || pops[1] !== 32'h4 || nxt !== 32'h8) begin
      n_bad++; $display("FAIL bp_order: got pops=%p next=%h want 0,4 next=8", pops, nxt);
    end
    n_cmp++;
  endtask

  task automatic test_redirect_wait();
    bit done = 0, saw8 = 0, got = 0;
    logic [31:0] nxt = 32'hDEAD_BEEF;
    g_ready = 1; lat = 3; lat_rand = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!done && bus.imem_req && bus.imem_addr == 32'h8) begin
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100; done = 1;
      end else if (done) begin
        if (!got && bus.imem_req && bus.imem_addr != 32'h8) begin got = 1; nxt = bus.imem_addr; end
      end
      eval();
      if (obs() !== exp_vec) begin n_bad++; $display("FAIL redir_wait c%0d: got %h want %h", c, obs(), exp_vec); end
      n_cmp++;
      if (done && bus.dec_valid && bus.instr_pc == 32'h8) saw8 = 1;
    end
    if (!done || saw8 || nxt !== 32'h100) begin
      n_bad++; $display("FAIL redir_wait_result: got hit=%b saw8=%b next=%h want 1/0/100", done, saw8, nxt);
    end
    n_cmp++;
  endtask

  task automatic test_redirect_ack_pop();
    bit hit = 0, got = 0;
    logic [31:0] rpc, first = 32'hDEAD_BEEF;
    g_ready = 0; lat = 0; lat_rand = 0;
    do_reset();
    rpc = $urandom | 32'h2;
    for (int c = 0; c < 12 && !hit; c++) begin
      tick();
      if (bus.imem_ack && bus.dec_valid) begin
        hit = 1;
        bus.dec_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = rpc;
      end
      eval();
      if (obs() !== exp_vec) begin n_bad++; $display("FAIL ack_pop c%0d: got %h want %h", c, obs(), exp_vec); end
      n_cmp++;
    end
    tick(); eval();
    if (!hit || bus.dec_valid !== 1'b0) begin
      n_bad++; $display("FAIL ack_pop_flush: got hit=%b valid=%b want 1/0", hit, bus.dec_valid);
    end
    n_cmp++;
    g_ready = 1;
    for (int c = 0; c < 10; c++) begin
      tick(); eval();
      if (obs() !== exp_vec) begin n_bad++; $display("FAIL ack_pop_after c%0d: got %h want %h", c, obs(), exp_vec); end
      n_cmp++;
      if (!got && bus.dec_valid) begin got = 1; first = bus.instr_pc; end
    end
    if (first !== (rpc & 32'hFFFF_FFFC)) begin
      n_bad++; $display("FAIL ack_pop_target: got %h want %h", first, rpc & 32'hFFFF_FFFC);
    end
    n_cmp++;
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    g_ready = 0; lat = 3; lat_rand = 0;
    do_reset();
    for (int c = 0; c < 30 && !hit; c++) begin
      tick(); eval();
      if (obs() !== exp_vec) begin n_bad++; $display("FAIL arst_pre c%0d: got %h want %h", c, obs(), exp_vec); end
      n_cmp++;
      if (m_q.size() == 1 && m_out) hit = 1;
    end
    #1 rst_n = 1'b0;
    #1;
    if (!hit || {bus.imem_req, bus.dec_valid, bus.opcode, bus.func} !== 13'h0) begin
      n_bad++; $display("FAIL arst_now: got hit=%b req=%b valid=%b op=%h fn=%h want 1/0/0/0/0",
                        hit, bus.imem_req, bus.dec_valid, bus.opcode, bus.func);
    end
    n_cmp++;
    bus.imem_ack = 1'b0; mw = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    logic [31:0] acks[$];
    g_ready = 1; lat = 1; lat_rand = 0;
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    eval();
    if (obs() !== exp_vec) begin n_bad++; $display("FAIL wrap_r: got %h want %h", obs(), exp_vec); end
    n_cmp++;
    tick(); eval();
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_bad++; $display("FAIL wrap_req: got %b/%h want 1/fffffffc", bus.imem_req, bus.imem_addr);
    end
    n_cmp++;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin tick(); eval(); end
      if (obs() !== exp_vec) begin n_bad++; $display("FAIL wrap c%0d: got %h want %h", c, obs(), exp_vec); end
      n_cmp++;
      if (bus.imem_ack) begin
        acks.push_back(bus.imem_addr);
        if (bus.imem_addr == 32'hFFFF_FFFC) begin
`ifdef FETCH_BYPASS_EN
          if (bus.dec_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_bypass: got valid=%b want 1", bus.dec_valid); end
`else
          if (bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_nobypass: got valid=%b want 0", bus.dec_valid); end
`endif
          n_cmp++;
        end
      end
    end
    if (acks.size() < 2 || acks[0] !== 32'hFFFF_FFFC || acks[1] !== 32'h0) begin
      n_bad++; $display("FAIL wrap_seq: got %p want fffffffc,0", acks);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    lat_rand = 1; g_ready = 1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      g_ready = ($urandom_range(0, 3) != 0);
      tick();
      if ($urandom_range(0, 15) == 0) begin
        bus.redirect = 1'b1; bus.redirect_pc = $urandom;
      end
      eval();
      if (obs() !== exp_vec) begin n_bad++; $display("FAIL random c%0d: got %h want %h", c, obs(), exp_vec); end
      n_cmp++;
    end
    lat_rand = 0;
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0; bus.dec_ready = 1'b0;
    mw = 0; cur_lat = 1;
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_async_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
